// File: rtl/uart_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_cmd_master: serialises 16-bit commands as UART frames and     |
// | captures one-byte read responses.                     Rev 1.0      |
// +--------------------------------------------------------------------+
module uart_cmd_master #(
  parameter int CLK_DIV    = 434,
  parameter int PARITY     = 2,
  parameter int GAP_CYC    = 100,
  parameter int RD_TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_in,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  output logic        tx,
  input  logic        rx,
  output logic [7:0]  rd_data,
  output logic        rd_vld,
  output logic [1:0]  rd_err
);
  localparam int NBITS   = (PARITY != 0) ? 11 : 10;
  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int WW      = $clog2(RD_TIMEOUT + 1);

  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [3:0]    LAST_BIT  = 4'(NBITS - 1);
  localparam logic [WW-1:0] TIMEOUT   = WW'(RD_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE, ST_TX0, ST_GAP, ST_TX1, ST_RX_WAIT, ST_RX_BITS, ST_DONE
  } state_t;

  state_t        state, state_nx;
  logic [15:0]   cmd;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [WW-1:0] wait_cnt;
  logic          rx_meta, rx_s, rx_prev;
  logic [7:0]    rx_shift;
  logic          rx_par;
  logic          tx_nx;
  logic          tick, frame_end, rx_fall, timed_out;
  logic [7:0]    tx_byte;

  function automatic logic par_of(input logic [7:0] b);
    return (PARITY == 1) ? ~^b : ^b;
  endfunction

  // Frame position 0 is the start bit, 1..8 data LSB first, then parity/stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic r;
    if (idx == 4'd0)                    r = 1'b0;
    else if (idx <= 4'd8)               r = b[3'(idx - 4'd1)];
    else if (idx == 4'd9 && PARITY != 0) r = par_of(b);
    else                                r = 1'b1;
    return r;
  endfunction

  assign tick      = (cnt == '0);
  assign frame_end = tick && (bit_idx == LAST_BIT);
  assign rx_fall   = rx_prev && !rx_s;
  assign timed_out = (wait_cnt >= TIMEOUT);
  assign tx_byte   = (state == ST_TX1) ? cmd[7:0] : cmd[15:8];
  assign cmd_rdy   = (state == ST_IDLE);
  assign rd_vld    = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_nx    = 1'b1;
    case (state)
      ST_IDLE: if (cmd_vld) begin
        state_nx = ST_TX0;
        tx_nx    = 1'b0;
      end
      ST_TX0, ST_TX1: begin
        tx_nx = tick ? frame_bit(tx_byte, bit_idx + 4'd1) : tx;
        if (frame_end) begin
          tx_nx = 1'b1;
          if (state == ST_TX1)  state_nx = ST_IDLE;
          else if (!cmd[15])    state_nx = ST_RX_WAIT;
          else if (GAP_CYC == 0) begin
            state_nx = ST_TX1;
            tx_nx    = 1'b0;
          end
          else                  state_nx = ST_GAP;
        end
      end
      ST_GAP: if (tick) begin
        state_nx = ST_TX1;
        tx_nx    = 1'b0;
      end
      ST_RX_WAIT: begin
        if (timed_out)    state_nx = ST_DONE;
        else if (rx_fall) state_nx = ST_RX_BITS;
      end
      ST_RX_BITS: if (tick) begin
        if (bit_idx == 4'd0 && rx_s) state_nx = ST_RX_WAIT;
        else if (bit_idx == LAST_BIT) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      wait_cnt <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
      rd_data  <= '0;
      rd_err   <= '0;
      tx       <= 1'b1;
    end else begin
      tx <= tx_nx;
      // The timeout budget keeps running through false starts.
      if (state == ST_RX_WAIT || state == ST_RX_BITS) begin
        if (!timed_out) wait_cnt <= wait_cnt + WW'(1);
      end else begin
        wait_cnt <= '0;
      end
      case (state)
        ST_IDLE: if (cmd_vld) begin
          cmd     <= cmd_in;
          cnt     <= BIT_LOAD;
          bit_idx <= '0;
        end
        ST_TX0, ST_TX1, ST_GAP: begin
          if (!tick) begin
            cnt <= cnt - CW'(1);
          end else begin
            bit_idx <= (state == ST_GAP || frame_end) ? 4'd0 : bit_idx + 4'd1;
            cnt     <= (state == ST_TX0 && frame_end && cmd[15] && GAP_CYC > 0)
                       ? GAP_LOAD : BIT_LOAD;
          end
        end
        ST_RX_WAIT: begin
          if (timed_out) begin
            rd_data <= '0;
            rd_err  <= 2'd3;
          end else if (rx_fall) begin
            cnt     <= HALF_LOAD;
            bit_idx <= '0;
          end
        end
        ST_RX_BITS: begin
          if (!tick) begin
            cnt <= cnt - CW'(1);
          end else begin
            cnt     <= BIT_LOAD;
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx >= 4'd1 && bit_idx <= 4'd8) rx_shift <= {rx_s, rx_shift[7:1]};
            if (PARITY != 0 && bit_idx == 4'd9)     rx_par   <= rx_s;
            if (bit_idx == LAST_BIT) begin
              rd_data <= rx_shift;
              rd_err  <= !rx_s ? 2'd2
                       : (PARITY != 0 && rx_par != par_of(rx_shift)) ? 2'd1 : 2'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_cmd_master: directed vector bench for uart_cmd_master.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_uart_cmd_master;
  localparam int CLK_DIV    = 8;
  localparam int PARITY     = 2;
  localparam int GAP_CYC    = 5;
  localparam int RD_TIMEOUT = 200;
  localparam int F          = 11 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd_in = '0;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic        tx;
  logic        rx = 1'b1;
  logic [7:0]  rd_data;
  logic        rd_vld;
  logic [1:0]  rd_err;

  int checks = 0;
  int errors = 0;

  uart_cmd_master #(
    .CLK_DIV(CLK_DIV), .PARITY(PARITY), .GAP_CYC(GAP_CYC), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .tx(tx), .rx(rx), .rd_data(rd_data), .rd_vld(rd_vld), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  // Expected tx frame bytes/parity and rx response are all hand-computed (even parity).
  typedef struct packed {
    logic [15:0] cmd;
    logic [7:0]  b0;
    logic        p0;
    logic [7:0]  b1;
    logic        p1;
    logic [7:0]  resp;
    logic        rpar;
    logic        rstop;
    logic [7:0]  exp_data;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  task automatic send_cmd(input logic [15:0] c);
    int n;
    n = 0;
    cmd_in  = c;
    cmd_vld = 1'b1;
    while (cmd_rdy !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cmd_rdy !== 1'b1) bound_fail("accept");
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic wait_start(input int bound, output int n);
    n = 0;
    while (tx !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) bound_fail("tx_start");
  endtask

  // Entered on the first start-bit cycle; samples every bit at its centre.
  task automatic capture_frame(output logic [10:0] bits);
    for (int b = 0; b < 11; b++) begin
      repeat ((b == 0) ? CLK_DIV / 2 : CLK_DIV) @(negedge clk);
      bits[b] = tx;
    end
  endtask

  task automatic drive_resp(input logic [7:0] d, input logic p, input logic stop);
    logic [10:0] fr;
    fr = {stop, p, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      rx = fr[b];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_rdvld(input int bound, output int n, output logic [7:0] d,
                            output logic [1:0] e);
    bit found;
    n = 0; found = 0; d = '0; e = '0;
    while (!found && n < bound) begin
      if (rd_vld === 1'b1) begin
        found = 1;
        d = rd_data;
        e = rd_err;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!found) bound_fail("rd_vld");
    else begin
      @(negedge clk);
      check("rd_vld_pulse", rd_vld, 1'b0);
    end
  endtask

  task automatic do_cmd(input vec_t v, input string tag);
    int n;
    logic [10:0] fr;
    logic [7:0]  d;
    logic [1:0]  e;
    send_cmd(v.cmd);
    wait_start(200, n);
    check($sformatf("%s_start_lat", tag), n, 0);
    capture_frame(fr);
    check($sformatf("%s_frame0", tag), fr, {1'b1, v.p0, v.b0, 1'b0});
    if (v.cmd[15]) begin
      // 3 stop cycles left after the centre sample, the gap, then the start cycle.
      wait_start(200, n);
      check($sformatf("%s_gap", tag), n, GAP_CYC + 4);
      capture_frame(fr);
      check($sformatf("%s_frame1", tag), fr, {1'b1, v.p1, v.b1, 1'b0});
    end else begin
      repeat (10) @(negedge clk);
      fork
        drive_resp(v.resp, v.rpar, v.rstop);
        wait_rdvld(300, n, d, e);
      join
      check($sformatf("%s_rd_data", tag), d, v.exp_data);
      check($sformatf("%s_rd_err", tag), e, v.exp_err);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cyc, accepts, late;
    logic [7:0]  d;
    logic [1:0]  e;
    logic [10:0] fr;
    logic [15:0] q [3];
    logic [10:0] hs_frames [5];
    vec_t rv;

    //            cmd       b0    p0    b1    p1    resp  rpar  stop  data  err
    vecs[0] = '{16'h85A3, 8'h85, 1'b1, 8'hA3, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 2'd0};
    vecs[1] = '{16'h1200, 8'h12, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 2'd0};
    vecs[2] = '{16'h1200, 8'h12, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h3C, 2'd1};
    vecs[3] = '{16'h1200, 8'h12, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 2'd2};
    vecs[4] = '{16'h7F01, 8'h7F, 1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 2'd0};
    vecs[5] = '{16'h2A00, 8'h2A, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 2'd1};
    vecs[6] = '{16'h00FF, 8'h00, 1'b0, 8'h00, 1'b0, 8'h81, 1'b0, 1'b0, 8'h81, 2'd2};
    vecs[7] = '{16'h55AA, 8'h55, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 2'd0};

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_cmd_rdy", cmd_rdy, 1'b1);
    check("rst_rd_vld", rd_vld, 1'b0);
    check("rst_rd_err", rd_err, 2'd0);
    check("rst_rd_data", rd_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_cmd(vecs[i], $sformatf("vec%0d", i));

    // Write completion: accept cycle counts as cycle 1.
    while (cmd_rdy !== 1'b1) @(negedge clk);
    cmd_in = 16'h85A3; cmd_vld = 1'b1; cyc = 1;
    @(negedge clk);
    cmd_vld = 1'b0; cyc = 2;
    check("rdy_drop", cmd_rdy, 1'b0);
    while (cmd_rdy !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("wr_rdy_cycle", cyc, 2 * F + GAP_CYC + 2);
    check("rd_data_held", rd_data, 8'hFF);

    // Timeout with a 2-cycle glitch 50 cycles into the wait.
    send_cmd(16'h0F00);
    wait_start(200, n);
    capture_frame(fr);
    check("to_frame0", fr, {1'b1, 1'b0, 8'h0F, 1'b0});
    repeat (F + 50 - (F - CLK_DIV / 2)) @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    wait_rdvld(400, n, d, e);
    check("to_latency", n, (F + RD_TIMEOUT + 1) - (F + 52));
    check("to_rd_data", d, 8'h00);
    check("to_rd_err", e, 2'd3);

    // Three queued commands with cmd_vld held high.
    q[0] = 16'h8123; q[1] = 16'h2200; q[2] = 16'h8456;
    while (cmd_rdy !== 1'b1) @(negedge clk);
    accepts = 0; late = 0;
    fork
      begin
        int idx, c;
        idx = 0; c = 0;
        cmd_in = q[0]; cmd_vld = 1'b1;
        while (idx < 3 && c < 3000) begin
          if (cmd_rdy === 1'b1) begin
            accepts++;
            @(negedge clk); c++;
            if (cmd_rdy !== 1'b0) late++;
            idx++;
            if (idx < 3) cmd_in = q[idx];
            else cmd_vld = 1'b0;
          end else begin
            @(negedge clk); c++;
          end
        end
        cmd_vld = 1'b0;
      end
      begin
        int m;
        for (int f = 0; f < 5; f++) begin
          wait_start(600, m);
          capture_frame(hs_frames[f]);
        end
      end
    join
    check("hs_accepts", accepts, 3);
    check("hs_rdy_after_accept", late, 0);
    check("hs_frame0", hs_frames[0], {1'b1, 1'b0, 8'h81, 1'b0});
    check("hs_frame1", hs_frames[1], {1'b1, 1'b1, 8'h23, 1'b0});
    check("hs_frame2", hs_frames[2], {1'b1, 1'b0, 8'h22, 1'b0});
    check("hs_frame3", hs_frames[3], {1'b1, 1'b0, 8'h84, 1'b0});
    check("hs_frame4", hs_frames[4], {1'b1, 1'b0, 8'h56, 1'b0});

    // Reset in the middle of frame position 4 of the second write frame.
    send_cmd(16'h85A3);
    repeat (F + GAP_CYC + 4 * CLK_DIV + CLK_DIV / 2) @(negedge clk);
    check("pre_rst_tx", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_cmd_rdy", cmd_rdy, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rv = '{16'hC35A, 8'hC3, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 2'd0};
    do_cmd(rv, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_cmd_master.md
# uart_cmd_master

Parametrised UART command master. It accepts 16-bit commands over a valid/ready handshake. Writes are serialised as two UART frames; reads send one frame, then capture a one-byte response on `rx`. It sits between the on-chip command source and an external UART register slave, and adds configurable parity, inter-frame gap, response timeout and error reporting.

## Interface
- `CLK_DIV`, 434: clk cycles per UART bit; must be ≥ 4.
- `PARITY`, 2: 0 = none, 1 = odd, 2 = even. Applies to both tx and rx frames.
- `GAP_CYC`, 100: idle-high cycles inserted between write frame 0 and frame 1; 0 means back-to-back.
- `RD_TIMEOUT`, 20000: cycles allowed between the end of the read command's stop bit and a valid start edge on `rx`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cmd_in`  in  16  bit [15]: 1 = write, 0 = read; [14:8]: 7-bit address; [7:0]: write data (ignored for reads).
- `cmd_vld`  in  1  command valid.
- `cmd_rdy`  out  1  high only in IDLE.
- `tx`  out  1  UART serial out, idle high.
- `rx`  in  1  UART serial in, asynchronous to `clk`.
- `rd_data`  out  8  read response byte; held until the next `rd_vld`.
- `rd_vld`  out  1  one-cycle pulse that completes every read command.
- `rd_err`  out  2  0 = ok, 1 = parity error, 2 = framing error (stop bit = 0), 3 = timeout. Valid with `rd_vld`.

## Operation
- Reset values: `tx`=1, `cmd_rdy`=1, `rd_vld`=0, `rd_err`=0, `rd_data`=0, FSM in IDLE, all counters 0. Reset asserted mid-frame returns `tx` to 1 immediately; no partial-frame completion.
- Accept occurs when `cmd_vld && cmd_rdy` at a rising edge. `cmd_in` is latched; `cmd_rdy` drops on the next cycle.
- Frame format: start bit (0), 8 data bits LSB first, a parity bit if `PARITY`≠0 (computed over the 8 data bits), then one stop bit (1).
- Frame 0 byte = {`cmd_in[15]`, `cmd_in[14:8]`}. Frame 1 (writes only) byte = `cmd_in[7:0]`.
- States:
  - IDLE → TX0 on accept.
  - TX0 → GAP (write) or RX_WAIT (read) at the end of the stop bit.
  - GAP → TX1 after `GAP_CYC` cycles, or immediately if `GAP_CYC`=0.
  - TX1 → IDLE at the end of the stop bit.
  - RX_WAIT → RX_BITS on a falling edge of synchronised `rx`.
  - RX_WAIT → DONE(timeout) when the wait counter reaches `RD_TIMEOUT`.
  - RX_BITS → DONE after the stop-bit sample.
  - DONE → IDLE after one cycle.
- `rx` passes through a 2-flop synchroniser. Edge detection uses the synchronised value and its previous cycle.
- Rx sampling is at mid-bit: first sample `CLK_DIV/2` (integer) cycles after the detected edge, then every `CLK_DIV` cycles.
- If the start-bit sample is 1, it is a false start: return to RX_WAIT. The timeout counter is not reset.
- Error priority: framing > parity. On timeout, `rd_data` is forced to 0.
- `rx` activity outside RX_WAIT/RX_BITS is ignored. No response is expected for writes.
- `tx` is registered and glitch-free, and holds 1 in IDLE, GAP, RX_WAIT, RX_BITS and DONE.

## Timing
- Frame length F = (10 + (`PARITY`≠0)) × `CLK_DIV` cycles.
- The start bit of TX0 begins on the cycle after accept. Each bit lasts exactly `CLK_DIV` cycles.
- Write: `cmd_rdy` returns high 2F + `GAP_CYC` + 2 cycles after the accept edge. This covers 1 cycle to leave IDLE, 2F of frames, the gap, and 1 cycle in the last state.
- Read: `rd_vld` pulses on the cycle after the stop-bit sample. `cmd_rdy` rises on the following cycle.
- `rx`-to-sample latency is 2 cycles, from the synchroniser.
- The wait counter is 0 in the first RX_WAIT cycle. Timeout `rd_vld` fires exactly `RD_TIMEOUT`+1 cycles after entering RX_WAIT.
- Back-to-back commands: a command presented while `cmd_rdy`=0 waits. It is accepted the first cycle `cmd_rdy`=1, so no idle cycle beyond IDLE's one is needed.

## Test plan
- Write test (`CLK_DIV`=8, `PARITY`=2, `GAP_CYC`=5), cmd 0x85A3:
  - Required: `tx` shows 0, bits of 0x85 LSB-first, parity 1, stop 1.
  - Then 5 idle cycles, then 0, bits of 0xA3, parity 0, stop 1.
  - `cmd_rdy` returns high at cycle 2·88+5+2 = 183.
- Read test, cmd 0x1200: frame 0x12 is sent, and the bench answers with 0x3C, correct parity, stop 1. Required: `rd_vld` one cycle, `rd_data`=0x3C, `rd_err`=0.
- Parity error: same read, response 0x3C with flipped parity. Required: `rd_err`=1, `rd_data`=0x3C. With the stop bit also 0, `rd_err`=2.
- Timeout and false start (`RD_TIMEOUT`=200): the bench sends no response, only a 2-cycle low glitch at cycle 50. Required: no rx capture, and `rd_vld` with `rd_err`=3 and `rd_data`=0 at RX_WAIT entry +201.
- Handshake: `cmd_vld` held high with 3 queued commands (write, read, write). Required: exactly 3 accepts, each on the first `cmd_rdy`=1 cycle, and no frame overlap.
- Reset mid-frame: assert `rst_n` during bit 4 of TX1. Required: `tx`=1 and `cmd_rdy`=1 asynchronously. After release, a new command transmits correctly.
